cla_add_sequencer: RTL and testbench
====================================

// Module: cla_add_sequencer
// PURPOSE
//  Multi-precision add controller. Sequences one shared 16-bit CLA adder (CLA_Adder_dat) over
//  WORDS slices, least-significant slice first, chaining the carry through a register.
//  Produces a WORDS*16-bit sum plus carry-out and signed overflow. Valid/ready on both sides.
//  Sits between an operand source and a result consumer; one operation in flight at a time.
// PARAMETERS
//  WORDS  4  number of 16-bit slices; total operand width = WORDS*16; legal range 1..16
// PORTS
//  clk        in   1          single clock, rising edge
//  reset      in   1          asynchronous, active-high; clears all state
//  in_valid   in   1          operand presented
//  in_ready   out  1          block can accept operands (IDLE only)
//  a_in       in   WORDS*16   operand A
//  b_in       in   WORDS*16   operand B
//  c_in       in   1          carry-in to slice 0
//  out_valid  out  1          result valid, held until out_ready
//  out_ready  in   1          consumer accepts result
//  sum_out    out  WORDS*16   sum, registered
//  c_out      out  1          carry-out of top slice, registered
//  ovf_out    out  1          signed overflow: a_msb==b_msb && sum_msb!=a_msb
// BEHAVIOUR
//  Reset values: in_ready=0 while reset high, 1 after release; out_valid=0; sum_out=0;
//   c_out=0; ovf_out=0; state=IDLE; idx=0; carry reg=0; operand regs=0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready, latch a_in/b_in into a_reg/b_reg, carry<=c_in,
//   idx<=0, go RUN. No in_valid: stay.
//  RUN: in_ready=0. Adder inputs = a_reg/b_reg slice [idx*16 +: 16], cin = carry.
//   Each cycle: sum_reg slice idx <= adder Sum; carry <= adder C_Out; idx++.
//   When idx==WORDS-1: latch c_out <= C_Out, compute ovf_out, go DONE. idx does not wrap.
//  DONE: out_valid=1; sum_out/c_out/ovf_out stable. On out_ready: out_valid<=0, go IDLE.
//   No zero-bubble path: new operands are accepted at the earliest in the cycle after
//   IDLE is re-entered.
//  Latency: accept at edge N -> out_valid high from edge N+WORDS. Throughput: 1 op per
//   WORDS+2 cycles with out_ready tied high.
//  in_valid during RUN/DONE is ignored (in_ready=0); the source must hold it.
//  out_ready while not in DONE is ignored. sum_out holds its last result in IDLE/RUN;
//   it is overwritten slice-by-slice in RUN, and only out_valid qualifies it.
//  WORDS=1: RUN lasts one cycle; idx is 1 bit wide, constant 0.
//  reset asserted mid-RUN or mid-DONE: abort immediately; all regs/outputs return to reset
//   values with no handshake. Any partial result is discarded.
//  Counter width = max(1, $clog2(WORDS)). All arithmetic is unsigned modulo 2^16 per slice,
//   done only by the adder instance; the block contains no '+' on operand data.
// STRUCTURE
//  Package cla_seq_pkg: SLICE_W=16 localparam; typedef enum logic[1:0] {IDLE,RUN,DONE} state_t;
//   typedef logic [SLICE_W-1:0] slice_t.
//  Single sub-module: the existing CLA_Adder_dat instance, combinational, driven by a slice mux.
//  One always_ff for state/idx/carry/regs, one always_comb for next state and adder operands.
// TESTING  (WORDS=4 unless noted)
//  1 A=64'h0000_0000_0000_FFFF, B=64'h1, cin=0 -> sum=64'h0000_0000_0001_0000, c_out=0,
//    ovf=0; out_valid exactly 4 cycles after the accept edge.
//  2 A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> sum=0, c_out=1, ovf=0 (carry through all slices).
//  3 A=64'h7FFF_FFFF_FFFF_FFFF, B=64'h1, cin=0 -> sum=64'h8000_0000_0000_0000, c_out=0, ovf=1.
//  4 out_ready low 10 cycles in DONE -> outputs stable, in_ready=0; a second in_valid pulse
//    is not accepted; that op is accepted once back in IDLE with in_valid held.
//  5 reset pulse in RUN at idx=2 -> out_valid=0, sum_out=0, state IDLE at once; in_ready=1
//    the cycle after release; next op (case 1) completes correctly.
//  6 1000 random A/B/cin with random out_ready; also WORDS=1 build -> {c_out,sum}==A+B+cin,
//    ovf matches the sign rule, and every result is seen exactly once.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg
//   Shared definitions for the multi-precision add sequencer.
//   SLICE_W : width of one adder slice
//   state_t : controller states (IDLE -> RUN -> DONE -> IDLE)
//   slice_t : one 16-bit operand/sum slice
package cla_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [SLICE_W-1:0] slice_t;

endpackage

// File: rtl/CLA_Adder_dat.sv
// CLA_Adder_dat
//   Combinational 16-bit carry-lookahead adder built from four 4-bit groups.
//   Group generate/propagate terms feed a lookahead unit that produces the
//   group carries directly; bits inside a group resolve from their group carry.
// Ports
//   A, B   in  16  addends
//   C_In   in  1   carry into bit 0
//   Sum    out 16  A + B + C_In modulo 2^16
//   C_Out  out 1   carry out of bit 15
module CLA_Adder_dat
    import cla_seq_pkg::*;
(
    input  slice_t A,
    input  slice_t B,
    input  logic   C_In,
    output slice_t Sum,
    output logic   C_Out
);

    slice_t     gen;
    slice_t     prop;
    slice_t     carry;
    logic [3:0] grpGen;
    logic [3:0] grpProp;
    logic [4:0] grpCarry;

    // Bit and group generate/propagate, then lookahead group carries
    always_comb begin
        gen      = A & B;
        prop     = A ^ B;
        grpGen   = '0;
        grpProp  = '0;
        grpCarry = '0;
        carry    = '0;

        for (int g = 0; g < 4; g++) begin
            grpGen[g] = gen[4*g+3]
                      | (prop[4*g+3] & gen[4*g+2])
                      | (prop[4*g+3] & prop[4*g+2] & gen[4*g+1])
                      | (prop[4*g+3] & prop[4*g+2] & prop[4*g+1] & gen[4*g]);
            grpProp[g] = &prop[4*g +: 4];
        end

        // Each group carry is expanded from C_In, not rippled through groups
        grpCarry[0] = C_In;
        grpCarry[1] = grpGen[0] | (grpProp[0] & C_In);
        grpCarry[2] = grpGen[1] | (grpProp[1] & grpGen[0])
                    | (grpProp[1] & grpProp[0] & C_In);
        grpCarry[3] = grpGen[2] | (grpProp[2] & grpGen[1])
                    | (grpProp[2] & grpProp[1] & grpGen[0])
                    | (grpProp[2] & grpProp[1] & grpProp[0] & C_In);
        grpCarry[4] = grpGen[3] | (grpProp[3] & grpGen[2])
                    | (grpProp[3] & grpProp[2] & grpGen[1])
                    | (grpProp[3] & grpProp[2] & grpProp[1] & grpGen[0])
                    | (grpProp[3] & grpProp[2] & grpProp[1] & grpProp[0] & C_In);

        for (int g = 0; g < 4; g++) begin
            carry[4*g] = grpCarry[g];
            for (int k = 1; k < 4; k++) begin
                carry[4*g+k] = gen[4*g+k-1] | (prop[4*g+k-1] & carry[4*g+k-1]);
            end
        end

        Sum   = prop ^ carry;
        C_Out = grpCarry[4];
    end

endmodule

// File: rtl/cla_add_sequencer.sv
// cla_add_sequencer
//   Multi-precision adder: walks one shared 16-bit CLA over WORDS slices,
//   least-significant first, carrying between slices through a register.
//   One operation in flight; valid/ready handshake on both sides.
// Ports
//   clk        in  1         rising-edge clock
//   reset      in  1         asynchronous active-high reset
//   in_valid   in  1         operands presented
//   in_ready   out 1         high only in IDLE (and not in reset)
//   a_in,b_in  in  WORDS*16  operands
//   c_in       in  1         carry into slice 0
//   out_valid  out 1         result valid until out_ready
//   out_ready  in  1         consumer accepts result
//   sum_out    out WORDS*16  registered sum
//   c_out      out 1         registered carry out of the top slice
//   ovf_out    out 1         registered signed overflow
module cla_add_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORDS*SLICE_W-1:0] a_in,
    input  logic [WORDS*SLICE_W-1:0] b_in,
    input  logic                     c_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*SLICE_W-1:0] sum_out,
    output logic                     c_out,
    output logic                     ovf_out
);

    localparam int W     = WORDS * SLICE_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             c_reg;
    logic             ovf_reg;
    slice_t           a_slice;
    slice_t           b_slice;
    slice_t           add_sum;
    logic             add_cout;

    CLA_Adder_dat u_adder (
        .A     (a_slice),
        .B     (b_slice),
        .C_In  (carry),
        .Sum   (add_sum),
        .C_Out (add_cout)
    );

    // Slice mux feeding the shared adder, plus next-state decode
    always_comb begin
        state_next = state;
        a_slice    = '0;
        b_slice    = '0;

        for (int i = 0; i < WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                a_slice = a_reg[i*SLICE_W +: SLICE_W];
                b_slice = b_reg[i*SLICE_W +: SLICE_W];
            end
        end

        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, slice counter, inter-slice carry, operand and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            c_reg   <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        carry <= c_in;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum_reg[i*SLICE_W +: SLICE_W] <= add_sum;
                        end
                    end
                    carry <= add_cout;
                    // Top slice: its adder MSB is the final sum MSB
                    if (idx == LAST_IDX) begin
                        c_reg   <= add_cout;
                        ovf_reg <= (a_reg[W-1] == b_reg[W-1]) &&
                                   (add_sum[SLICE_W-1] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // in_ready is gated by reset so the source sees no acceptance during reset
    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == DONE);
    assign sum_out   = sum_reg;
    assign c_out     = c_reg;
    assign ovf_out   = ovf_reg;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// tb_cla_add_sequencer
//   Self-checking bench: a WORDS=4 instance for directed and random
//   scoreboard tests, and a WORDS=1 instance for the single-slice build.
module tb_cla_add_sequencer;

    localparam int NRAND = 1000;
    localparam int NRAND1 = 200;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum_out;
    logic        c_out;
    logic        ovf_out;

    logic        in_valid1;
    logic        in_ready1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        c_in1;
    logic        out_valid1;
    logic        out_ready1;
    logic [15:0] sum1;
    logic        c_out1;
    logic        ovf_out1;

    int checkCount = 0;
    int passCount  = 0;
    int gotCount   = 0;

    logic [65:0] expQueue[$];

    cla_add_sequencer #(.WORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .c_out     (c_out),
        .ovf_out   (ovf_out)
    );

    cla_add_sequencer #(.WORDS(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a_in      (a1),
        .b_in      (b1),
        .c_in      (c_in1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum_out   (sum1),
        .c_out     (c_out1),
        .ovf_out   (ovf_out1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, carry, sum} for a 64-bit add
    function automatic logic [65:0] model64(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin);
        logic [64:0] full;
        logic        ovf;
        full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        ovf  = (a[63] == b[63]) && (full[63] != a[63]);
        return {ovf, full};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        logic [16:0] full;
        logic        ovf;
        full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        ovf  = (a[15] == b[15]) && (full[15] != a[15]);
        return {ovf, full};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Present operands and wait (bounded) for the accepting edge
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic cin);
        int cyc;
        a_in     = a;
        b_in     = b;
        c_in     = cin;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!in_ready) checkOutput("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called right after the accept edge; checks latency and the result
    task automatic waitResult(input string tag, input logic [65:0] exp);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({tag, "_latency"}, cyc, 4);
        checkOutput({tag, "_result"}, {ovf_out, c_out, sum_out}, exp);
    endtask

    task automatic finishOp(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, out_valid, 0);
        checkOutput({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic [65:0] exp;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;
        logic [17:0] exp1;
        int          cyc;

        reset = 1'b1;
        in_valid = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0; out_ready1 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_outputs", {out_valid, ovf_out, c_out, sum_out}, 0);
        checkOutput("rst_w1_outputs", {in_ready1, out_valid1, ovf_out1, c_out1, sum1}, 0);
        reset = 1'b0;
        #1;
        checkOutput("rel_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Case 1: carry from slice 0 into slice 1
        applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        waitResult("c1", {1'b0, 1'b0, 64'h0000_0000_0001_0000});
        finishOp("c1");

        // Case 2: carry-in ripples through every slice
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        waitResult("c2", {1'b0, 1'b1, 64'h0});
        finishOp("c2");

        // Case 3: positive + positive gives negative
        applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        waitResult("c3", {1'b1, 1'b0, 64'h8000_0000_0000_0000});
        finishOp("c3");

        // Case 4: back-pressure in DONE; a second request must wait for IDLE
        applyStimulus(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b0);
        waitResult("c4", {1'b1, 1'b1, 64'h0000_0000_0000_0003});
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a_in = 64'h0123_4567_89AB_CDEF;
                b_in = 64'h1111_1111_1111_1111;
                c_in = 1'b1;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            checkOutput("c4_hold", {in_ready, out_valid, ovf_out, c_out, sum_out},
                        {2'b01, 1'b1, 1'b1, 64'h0000_0000_0000_0003});
        end
        finishOp("c4");
        applyStimulus(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1);
        waitResult("c4b", {1'b0, 1'b0, 64'h1234_5678_9ABC_DF01});
        finishOp("c4b");

        // Case 5: reset while idx == 2
        applyStimulus(64'h1111_2222_3333_4444, 64'h0001_0001_0001_0001, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("c5_abort", {in_ready, out_valid, ovf_out, c_out, sum_out}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("c5_ready", {in_ready, out_valid}, 2'b10);
        applyStimulus(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        waitResult("c5", {1'b0, 1'b0, 64'h0000_0000_0001_0000});
        finishOp("c5");

        // Case 6: random operands with random back-pressure, scoreboarded
        fork
            begin
                for (int n = 0; n < NRAND; n++) begin
                    ra = {$urandom, $urandom};
                    rb = {$urandom, $urandom};
                    rc = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 7) == 0) ra = '1;
                    if ($urandom_range(0, 7) == 0) rb = '0;
                    applyStimulus(ra, rb, rc);
                    expQueue.push_back(model64(ra, rb, rc));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin
                cyc = 0;
                while (gotCount < NRAND && cyc < 60000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        if (expQueue.size() == 0) begin
                            checkOutput("rand_unexpected", 1, 0);
                        end else begin
                            exp = expQueue.pop_front();
                            checkOutput("rand_result", {ovf_out, c_out, sum_out}, exp);
                        end
                        gotCount++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                if (gotCount < NRAND) checkOutput("rand_timeout", gotCount, NRAND);
                out_ready = 1'b0;
            end
        join
        checkOutput("rand_leftover", expQueue.size(), 0);

        // WORDS=1 build: one RUN cycle, result one edge after accept
        for (int n = 0; n < NRAND1; n++) begin
            a1 = 16'($urandom);
            b1 = 16'($urandom);
            c_in1 = 1'($urandom_range(0, 1));
            exp1 = model16(a1, b1, c_in1);
            cyc = 0;
            while (!in_ready1 && cyc < 20) begin
                @(posedge clk); #1;
                cyc++;
            end
            in_valid1 = 1'b1;
            @(posedge clk); #1;
            in_valid1 = 1'b0;
            @(posedge clk); #1;
            checkOutput("w1_valid", out_valid1, 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            checkOutput("w1_result", {ovf_out1, c_out1, sum1}, exp1);
            out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
